// File: rtl/multi_input_max_seq.sv
// Sequential max-finder: captures NUM_INPUTS operands, scans one per clock, returns max + index.
// Optional macro SIGNED_CMP_EN switches the compare to two's-complement.
module multi_input_max_seq #(
  parameter  int N          = 8,
  parameter  int NUM_INPUTS = 4,
  localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_INPUTS*N-1:0] inputs_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            largest,
  output logic [IDX_W-1:0]        largest_idx,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  state_t           state_reg;
  logic [N-1:0]     bank_reg [NUM_INPUTS];
  logic [N-1:0]     in_op    [NUM_INPUTS];
  logic [IDX_W-1:0] cnt_reg;
  logic [N-1:0]     largest_reg;
  logic [IDX_W-1:0] largest_idx_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
      assign in_op[gi] = inputs_flat[gi*N +: N];
    end
  endgenerate

  logic [N-1:0] cand;
  logic         cand_gt;
  assign cand = bank_reg[cnt_reg];

  // Strictly-greater only, so on ties the earlier (lower) index is kept.
`ifdef SIGNED_CMP_EN
  assign cand_gt = $signed(cand) > $signed(largest_reg);
`else
  assign cand_gt = cand > largest_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      largest_reg     <= '0;
      largest_idx_reg <= '0;
      in_ready_reg    <= 1'b1;
      out_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        bank_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              bank_reg[i] <= in_op[i];
            end
            largest_reg     <= in_op[0];
            largest_idx_reg <= '0;
            cnt_reg         <= IDX_W'(1);
            in_ready_reg    <= 1'b0;
            busy_reg        <= 1'b1;
            state_reg       <= SCAN;
          end
        end
        SCAN: begin
          if (cand_gt) begin
            largest_reg     <= cand;
            largest_idx_reg <= cnt_reg;
          end
          if (cnt_reg == LAST_IDX) begin
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign busy        = busy_reg;
  assign largest     = largest_reg;
  assign largest_idx = largest_idx_reg;

endmodule

// File: tb/tb_multi_input_max_seq.sv
// Directed bench for multi_input_max_seq (N=8, NUM_INPUTS=4); honours SIGNED_CMP_EN for the signed vector.
module tb_multi_input_max_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inputs_flat = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  largest;
  logic [1:0]  largest_idx;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int lat;

  always #5 clk = ~clk;

  multi_input_max_seq #(.N(8), .NUM_INPUTS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inputs_flat (inputs_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .largest     (largest),
    .largest_idx (largest_idx),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bank in IDLE; returns at the negedge after the capture edge.
  task automatic start_bank(input logic [31:0] flat);
    @(negedge clk);
    in_valid    = 1'b1;
    inputs_flat = flat;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    inputs_flat = 32'hFFFF_FFFF;
  endtask

  // Counts rising edges after the capture edge until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_iready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_bank(input string tag, input logic [31:0] flat,
                          input logic [7:0] exp_l, input logic [1:0] exp_i);
    start_bank(flat);
    wait_done(lat);
    check({tag, "_lat"}, lat, 32'd3);
    check({tag, "_largest"}, {24'b0, largest}, {24'b0, exp_l});
    check({tag, "_idx"}, {30'b0, largest_idx}, {30'b0, exp_i});
    $display("[TB] %s: largest=%0h idx=%0d latency=%0d", tag, largest, largest_idx, lat);
    accept(tag);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_largest", {24'b0, largest}, 32'd0);
    check("rst_idx", {30'b0, largest_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic bank; inputs_flat is scrambled and in_valid pulsed during SCAN
    start_bank({8'h10, 8'h7F, 8'h80, 8'h05});
    check("scan_busy", {31'b0, busy}, 32'd1);
    check("scan_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1;
    wait_done(lat);
    check("basic_lat", lat, 32'd3);
    check("basic_largest", {24'b0, largest}, 32'h80);
    check("basic_idx", {30'b0, largest_idx}, 32'd1);
    $display("[TB] basic: largest=%0h idx=%0d latency=%0d", largest, largest_idx, lat);

    // Hold in DONE for 10 cycles with in_valid still high
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", {31'b0, out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, in_ready}, 32'd0);
      check("hold_largest", {24'b0, largest}, 32'h80);
      check("hold_idx", {30'b0, largest_idx}, 32'd1);
    end
    $display("[TB] hold: out_valid stayed high 10 cycles");
    in_valid = 1'b0;
    accept("hold");

    run_bank("ties", {8'h42, 8'h42, 8'h11, 8'h42}, 8'h42, 2'd0);
    run_bank("zeros", 32'h0000_0000, 8'h00, 2'd0);

    // Back-to-back with out_ready held high and the next bank already waiting
    out_ready = 1'b1;
    @(negedge clk);
    in_valid    = 1'b1;
    inputs_flat = {8'h00, 8'hFF, 8'h00, 8'h00};
    @(posedge clk);
    @(negedge clk);
    inputs_flat = {8'h01, 8'h00, 8'h00, 8'h00};
    wait_done(lat);
    check("b2b_a_lat", lat, 32'd3);
    check("b2b_a_largest", {24'b0, largest}, 32'hFF);
    check("b2b_a_idx", {30'b0, largest_idx}, 32'd2);
    $display("[TB] b2b_a: largest=%0h idx=%0d latency=%0d", largest, largest_idx, lat);
    @(negedge clk);
    check("b2b_idle_in_ready", {31'b0, in_ready}, 32'd1);
    check("b2b_idle_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_b_captured", {31'b0, busy}, 32'd1);
    wait_done(lat);
    check("b2b_b_lat", lat, 32'd3);
    check("b2b_b_largest", {24'b0, largest}, 32'h01);
    check("b2b_b_idx", {30'b0, largest_idx}, 32'd3);
    $display("[TB] b2b_b: largest=%0h idx=%0d latency=%0d", largest, largest_idx, lat);
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_exit", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of SCAN
    start_bank({8'hEE, 8'hDD, 8'hCC, 8'hBB});
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    $display("[TB] mid_rst: in_ready=%0b out_valid=%0b busy=%0b", in_ready, out_valid, busy);
    @(negedge clk);
    rst_n = 1'b1;
    run_bank("post_rst", {8'h09, 8'h03, 8'h0A, 8'h01}, 8'h0A, 2'd1);

`ifdef SIGNED_CMP_EN
    run_bank("signed", {8'h80, 8'h7F, 8'hFF, 8'h01}, 8'h7F, 2'd2);
`else
    run_bank("unsigned", {8'h80, 8'h7F, 8'hFF, 8'h01}, 8'hFF, 2'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_input_max_seq.md
Name: multi_input_max_seq

Overview:
- Sequential successor to the two-input largest-value comparator.
- Accepts NUM_INPUTS operands of width N in one handshake beat and stores them in an operand bank.
- Performs one compare per clock and returns the largest value plus its index over a valid/ready output handshake.
- Sits between the operand source and any consumer of the "largest" result in the comparator datapath.

Parameters:
- N, 8, operand width in bits (>=1).
- NUM_INPUTS, 4, operands per transaction (>=2).
- IDX_W, $clog2(NUM_INPUTS), width of the index output (derived, not overridden).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bank valid.
- in_ready  out  1  block can accept a bank.
- inputs_flat  in  NUM_INPUTS*N  operand k at bits [k*N +: N].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- largest  out  N  maximum operand.
- largest_idx  out  IDX_W  index of the maximum operand.
- busy  out  1  high while in SCAN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - largest=0, largest_idx=0, scan counter=0, operand bank=0.
  - Reset asserted mid-SCAN or mid-DONE aborts the transaction with no output.
- FSM states IDLE, SCAN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - Capture all operands.
    - Load largest=operand0, largest_idx=0, cnt=1.
    - Go to SCAN.
  - SCAN: busy=1, in_ready=0. Each cycle compare operand[cnt] against largest:
    - If strictly greater, load largest=operand[cnt] and largest_idx=cnt.
    - If cnt==NUM_INPUTS-1, go to DONE; otherwise cnt=cnt+1.
  - DONE: out_valid=1, in_ready=0. largest and largest_idx are held stable.
    - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency:
  - out_valid rises exactly NUM_INPUTS-1 rising edges after the capture edge (SCAN lasts NUM_INPUTS-1 cycles).
  - Minimum throughput is one transaction per NUM_INPUTS+1 cycles.
- Ties: the lowest index wins, because only strictly-greater values replace.
- Comparison is unsigned, MSB-first magnitude; all-equal operands return index 0.
- Handshake rules:
  - in_valid is ignored outside IDLE.
  - inputs_flat is sampled only on the capture edge; later changes do not affect the result.
  - out_valid, once high, stays high until out_ready is sampled high.
- Outputs are registered; there are no combinational paths from inputs to outputs except none (in_ready is a pure function of state).

Optional Feature:
- Macro: SIGNED_CMP_EN.
- Defined: operands and largest are treated as two's-complement. A MSB-differs compare picks the operand with MSB=0. Tie rule and latency are unchanged.
- Undefined: unsigned compare as above.

Test Plan:
- Reset then bank {3:0x10, 2:0x7F, 1:0x80, 0:0x05}, N=8, M=4 -> out_valid 3 edges after capture; largest=0x80, largest_idx=1.
- Ties {0x42,0x42,0x11,0x42} (idx3..0) -> largest=0x42, largest_idx=0. All-zero bank -> largest=0x00, idx=0.
- out_ready held low 10 cycles in DONE -> out_valid stays 1 and largest/idx stable. in_valid pulsed during SCAN/DONE -> ignored, in_ready=0.
- Back-to-back banks with out_ready=1 -> second capture one cycle after DONE exit; results {0xFF at idx2} then {0x01 at idx3, others 0x00}.
- rst_n pulsed low mid-SCAN -> out_valid=0, in_ready=1 immediately; the next bank {0x09,0x03,0x0A,0x01} gives 0x0A, idx1.
- With SIGNED_CMP_EN: {0x80,0x7F,0xFF,0x01} -> largest=0x7F, idx2; without the macro -> 0xFF, idx1.
